// File: rtl/cpu_pkg.sv
// Shared constants for the execute stage: ALU opcodes and the control values of a NOP bubble.
package cpu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic       NOP_RW      = 1'b1;
    localparam logic       NOP_MEM_RW  = 1'b1;
    localparam logic [3:0] NOP_BYTE_EN = 4'hF;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU. Shifts and LUI operate on operand B; unused opcodes yield zero.
module ex_alu
    import cpu_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int OP_BITS    = 4,
    parameter int SHIFT_BITS = 5
) (
    input  logic [BITS-1:0]       a,
    input  logic [BITS-1:0]       b,
    input  logic [SHIFT_BITS-1:0] shamt,
    input  logic [OP_BITS-1:0]    alu_op,
    output logic [BITS-1:0]       result
);

    always_comb begin
        result = '0;
        case (alu_op)
            OP_BITS'(ALU_ADD):  result = a + b;
            OP_BITS'(ALU_SUB):  result = a - b;
            OP_BITS'(ALU_AND):  result = a & b;
            OP_BITS'(ALU_OR):   result = a | b;
            OP_BITS'(ALU_XOR):  result = a ^ b;
            OP_BITS'(ALU_NOR):  result = ~(a | b);
            OP_BITS'(ALU_SLL):  result = b << shamt;
            OP_BITS'(ALU_SRL):  result = b >> shamt;
            OP_BITS'(ALU_SRA):  result = $unsigned($signed(b) >>> shamt);
            OP_BITS'(ALU_SLT):  result = BITS'($signed(a) < $signed(b));
            OP_BITS'(ALU_SLTU): result = BITS'(a < b);
            OP_BITS'(ALU_LUI):  result = b << (BITS / 2);
            default:            result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU / effective address, LL/SC reservation tracking,
// sticky halt, and the EX/MEM output register.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int REG_WORDS  = 32,
    parameter int ADDR_LEFT  = $clog2(REG_WORDS) - 1,
    parameter int OP_BITS    = 4,
    parameter int SHIFT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  atomic_s3,
    input  logic                  sel_mem_s3,
    input  logic                  check_link_s3,
    input  logic                  mem_rw_s3,
    input  logic                  rw_s3,
    input  logic                  load_link_s3,
    input  logic                  alu_imm_s3,
    input  logic                  halt_s3,
    input  logic [ADDR_LEFT:0]    waddr_s3,
    input  logic [ADDR_LEFT:0]    r1_addr_s3,
    input  logic [ADDR_LEFT:0]    r2_addr_s3,
    input  logic [BITS-1:0]       r1_data_s3,
    input  logic [BITS-1:0]       r2_data_s3,
    input  logic [BITS-1:0]       sign_ext_imm_s3,
    input  logic [SHIFT_BITS-1:0] shamt_s3,
    input  logic [OP_BITS-1:0]    alu_op_s3,
    input  logic [3:0]            byte_en_s3,
    input  logic                  rw_s4,
    input  logic                  sel_mem_s4,
    input  logic [ADDR_LEFT:0]    waddr_s4,
    input  logic [BITS-1:0]       alu_out_s4,
    input  logic                  rw_s5,
    input  logic [ADDR_LEFT:0]    waddr_s5,
    input  logic [BITS-1:0]       wdata_s5,
    output logic [BITS-1:0]       alu_out_s4_o,
    output logic [BITS-1:0]       wdata_s4_o,
    output logic [ADDR_LEFT:0]    waddr_s4_o,
    output logic                  rw_s4_o,
    output logic                  mem_rw_s4_o,
    output logic                  sel_mem_s4_o,
    output logic                  atomic_s4_o,
    output logic                  halt_s4_o,
    output logic [3:0]            byte_en_s4_o,
    output logic                  link_valid
);

    logic [BITS-1:0]    alu_out_d, alu_out_q, wdata_d, wdata_q;
    logic [ADDR_LEFT:0] waddr_d, waddr_q;
    logic               rw_d, rw_q, mem_rw_d, mem_rw_q, sel_mem_d, sel_mem_q;
    logic               atomic_d, atomic_q, halt_d, halt_q;
    logic [3:0]         byte_en_d, byte_en_q;
    logic               link_valid_d, link_valid_q, halted_d, halted_q;
    logic [BITS-1:0]    link_addr_d, link_addr_q;

    logic [BITS-1:0]    r1_fwd, r2_fwd, operand_b, alu_res, eff_addr;
    logic               is_mem, sc_ok;

    // A load in MEM (sel_mem_s4) has no data yet, so only ALU results forward from there.
    function automatic logic [BITS-1:0] fwd(
        input logic [ADDR_LEFT:0] addr,
        input logic [BITS-1:0]    data,
        input logic               rw4,
        input logic               sel_mem4,
        input logic [ADDR_LEFT:0] waddr4,
        input logic [BITS-1:0]    alu_out4,
        input logic               rw5,
        input logic [ADDR_LEFT:0] waddr5,
        input logic [BITS-1:0]    wdata5
    );
        fwd = data;
        if (addr != '0) begin
            if (!rw4 && !sel_mem4 && waddr4 == addr) fwd = alu_out4;
            else if (!rw5 && waddr5 == addr)          fwd = wdata5;
        end
    endfunction

    always_comb begin
        r1_fwd = fwd(r1_addr_s3, r1_data_s3, rw_s4, sel_mem_s4, waddr_s4, alu_out_s4,
                     rw_s5, waddr_s5, wdata_s5);
        r2_fwd = fwd(r2_addr_s3, r2_data_s3, rw_s4, sel_mem_s4, waddr_s4, alu_out_s4,
                     rw_s5, waddr_s5, wdata_s5);
        operand_b = alu_imm_s3 ? sign_ext_imm_s3 : r2_fwd;
        eff_addr  = r1_fwd + sign_ext_imm_s3;
        is_mem    = sel_mem_s3 | ~mem_rw_s3 | check_link_s3;
        sc_ok     = link_valid_q && (link_addr_q == eff_addr);
    end

    ex_alu #(
        .BITS       (BITS),
        .OP_BITS    (OP_BITS),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_alu (
        .a      (r1_fwd),
        .b      (operand_b),
        .shamt  (shamt_s3),
        .alu_op (alu_op_s3),
        .result (alu_res)
    );

    always_comb begin
        alu_out_d    = '0;
        wdata_d      = '0;
        waddr_d      = '0;
        rw_d         = NOP_RW;
        mem_rw_d     = NOP_MEM_RW;
        sel_mem_d    = 1'b0;
        atomic_d     = 1'b0;
        halt_d       = 1'b0;
        byte_en_d    = NOP_BYTE_EN;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        halted_d     = halted_q;

        if (!halted_q) begin
            // SC issued without sel_mem writes its pass/fail flag back through alu_out.
            if (check_link_s3 && !sel_mem_s3) alu_out_d = BITS'(sc_ok);
            else if (is_mem)                  alu_out_d = eff_addr;
            else                              alu_out_d = alu_res;

            wdata_d   = r2_fwd;
            waddr_d   = waddr_s3;
            rw_d      = rw_s3;
            mem_rw_d  = check_link_s3 ? ~sc_ok : mem_rw_s3;
            sel_mem_d = sel_mem_s3;
            atomic_d  = check_link_s3 ? sc_ok : atomic_s3;
            halt_d    = halt_s3;
            byte_en_d = byte_en_s3;
            halted_d  = halt_s3;

            if (check_link_s3) begin
                link_valid_d = 1'b0;
            end else if (!load_link_s3 && sel_mem_s3) begin
                link_valid_d = 1'b1;
                link_addr_d  = eff_addr;
            end else if (!mem_rw_s3 && eff_addr[BITS-1:2] == link_addr_q[BITS-1:2]) begin
                link_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q    <= '0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            rw_q         <= NOP_RW;
            mem_rw_q     <= NOP_MEM_RW;
            sel_mem_q    <= 1'b0;
            atomic_q     <= 1'b0;
            halt_q       <= 1'b0;
            byte_en_q    <= NOP_BYTE_EN;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            halted_q     <= 1'b0;
        end else begin
            alu_out_q    <= alu_out_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            rw_q         <= rw_d;
            mem_rw_q     <= mem_rw_d;
            sel_mem_q    <= sel_mem_d;
            atomic_q     <= atomic_d;
            halt_q       <= halt_d;
            byte_en_q    <= byte_en_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            halted_q     <= halted_d;
        end
    end

    assign alu_out_s4_o = alu_out_q;
    assign wdata_s4_o   = wdata_q;
    assign waddr_s4_o   = waddr_q;
    assign rw_s4_o      = rw_q;
    assign mem_rw_s4_o  = mem_rw_q;
    assign sel_mem_s4_o = sel_mem_q;
    assign atomic_s4_o  = atomic_q;
    assign halt_s4_o    = halt_q;
    assign byte_en_s4_o = byte_en_q;
    assign link_valid   = link_valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        atomic_s3, sel_mem_s3, check_link_s3, mem_rw_s3, rw_s3, load_link_s3, alu_imm_s3, halt_s3;
    logic [4:0]  waddr_s3, r1_addr_s3, r2_addr_s3, shamt_s3, waddr_s4, waddr_s5;
    logic [31:0] r1_data_s3, r2_data_s3, sign_ext_imm_s3, alu_out_s4, wdata_s5;
    logic [3:0]  alu_op_s3, byte_en_s3;
    logic        rw_s4, sel_mem_s4, rw_s5;
    logic [31:0] alu_out_s4_o, wdata_s4_o;
    logic [4:0]  waddr_s4_o;
    logic        rw_s4_o, mem_rw_s4_o, sel_mem_s4_o, atomic_s4_o, halt_s4_o, link_valid;
    logic [3:0]  byte_en_s4_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        atomic, sel_mem, check_link, mem_rw, rw, load_link, alu_imm, halt;
        logic [4:0]  waddr, r1_addr, r2_addr, shamt;
        logic [31:0] r1_data, r2_data, imm;
        logic [3:0]  op, byte_en;
        logic        rw4, sel_mem4, rw5;
        logic [4:0]  waddr4, waddr5;
        logic [31:0] alu_out4, wdata5;
    } txn_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        rw, mem_rw, sel_mem, atomic, halt;
        logic [3:0]  byte_en;
        logic        link_valid;
    } exp_t;

    localparam exp_t RESET_EXP = '{alu_out: 32'h0, wdata: 32'h0, waddr: 5'd0, rw: 1'b1, mem_rw: 1'b1,
                                   sel_mem: 1'b0, atomic: 1'b0, halt: 1'b0, byte_en: 4'hF, link_valid: 1'b0};

    logic [$bits(exp_t)-1:0] exp_q[$];

    // Reference model state: the reservation and the halt latch.
    logic        m_link_valid;
    logic [31:0] m_link_addr;
    logic        m_halted;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .atomic_s3(atomic_s3), .sel_mem_s3(sel_mem_s3), .check_link_s3(check_link_s3),
        .mem_rw_s3(mem_rw_s3), .rw_s3(rw_s3), .load_link_s3(load_link_s3),
        .alu_imm_s3(alu_imm_s3), .halt_s3(halt_s3),
        .waddr_s3(waddr_s3), .r1_addr_s3(r1_addr_s3), .r2_addr_s3(r2_addr_s3),
        .r1_data_s3(r1_data_s3), .r2_data_s3(r2_data_s3), .sign_ext_imm_s3(sign_ext_imm_s3),
        .shamt_s3(shamt_s3), .alu_op_s3(alu_op_s3), .byte_en_s3(byte_en_s3),
        .rw_s4(rw_s4), .sel_mem_s4(sel_mem_s4), .waddr_s4(waddr_s4), .alu_out_s4(alu_out_s4),
        .rw_s5(rw_s5), .waddr_s5(waddr_s5), .wdata_s5(wdata_s5),
        .alu_out_s4_o(alu_out_s4_o), .wdata_s4_o(wdata_s4_o), .waddr_s4_o(waddr_s4_o),
        .rw_s4_o(rw_s4_o), .mem_rw_s4_o(mem_rw_s4_o), .sel_mem_s4_o(sel_mem_s4_o),
        .atomic_s4_o(atomic_s4_o), .halt_s4_o(halt_s4_o), .byte_en_s4_o(byte_en_s4_o),
        .link_valid(link_valid)
    );

    always #5 clk = ~clk;

    function automatic txn_t nop_txn();
        txn_t t;
        t = '{atomic: 0, sel_mem: 0, check_link: 0, mem_rw: 1, rw: 1, load_link: 1, alu_imm: 0, halt: 0,
              waddr: 0, r1_addr: 0, r2_addr: 0, shamt: 0, r1_data: 0, r2_data: 0, imm: 0,
              op: 0, byte_en: 4'hF, rw4: 1, sel_mem4: 0, rw5: 1, waddr4: 0, waddr5: 0,
              alu_out4: 0, wdata5: 0};
        return t;
    endfunction

    function automatic exp_t observe();
        return {alu_out_s4_o, wdata_s4_o, waddr_s4_o, rw_s4_o, mem_rw_s4_o, sel_mem_s4_o,
                atomic_s4_o, halt_s4_o, byte_en_s4_o, link_valid};
    endfunction

    function automatic logic [31:0] ref_src(input txn_t t, input logic [4:0] a, input logic [31:0] d);
        if (a == 0) return d;
        if (!t.rw4 && !t.sel_mem4 && t.waddr4 == a) return t.alu_out4;
        if (!t.rw5 && t.waddr5 == a) return t.wdata5;
        return d;
    endfunction

    // Predicts the registered outputs for one issued op and advances model state.
    function automatic exp_t model_step(input txn_t t);
        exp_t        e;
        logic [31:0] a, r2, b, res, addr;
        logic        sc;
        e = RESET_EXP;
        e.link_valid = m_link_valid;
        if (m_halted) return e;
        a  = ref_src(t, t.r1_addr, t.r1_data);
        r2 = ref_src(t, t.r2_addr, t.r2_data);
        b  = t.alu_imm ? t.imm : r2;
        case (t.op)
            4'd0:    res = a + b;
            4'd1:    res = a + ~b + 32'd1;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = a ^ b;
            4'd5:    res = ~a & ~b;
            4'd6:    res = b * (32'd1 << t.shamt);
            4'd7:    res = b / (32'd1 << t.shamt);
            4'd8:    res = (b >> t.shamt) | (b[31] ? ~(32'hFFFF_FFFF >> t.shamt) : 32'h0);
            4'd9:    res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd10:   res = (longint'({32'h0, a}) < longint'({32'h0, b})) ? 32'd1 : 32'd0;
            4'd11:   res = {b[15:0], 16'h0000};
            default: res = 32'h0;
        endcase
        addr = a + t.imm;
        sc   = t.check_link && m_link_valid && (m_link_addr == addr);
        if (t.check_link && !t.sel_mem) e.alu_out = {31'h0, sc};
        else if (t.sel_mem || !t.mem_rw || t.check_link) e.alu_out = addr;
        else e.alu_out = res;
        e.wdata   = r2;
        e.waddr   = t.waddr;
        e.rw      = t.rw;
        e.mem_rw  = t.check_link ? !sc : t.mem_rw;
        e.sel_mem = t.sel_mem;
        e.atomic  = t.check_link ? sc : t.atomic;
        e.halt    = t.halt;
        e.byte_en = t.byte_en;
        if (t.check_link) m_link_valid = 1'b0;
        else if (!t.load_link && t.sel_mem) begin
            m_link_valid = 1'b1;
            m_link_addr  = addr;
        end else if (!t.mem_rw && (addr >> 2) == (m_link_addr >> 2)) m_link_valid = 1'b0;
        m_halted = t.halt;
        e.link_valid = m_link_valid;
        return e;
    endfunction

    task automatic drive(input txn_t t);
        atomic_s3 = t.atomic; sel_mem_s3 = t.sel_mem; check_link_s3 = t.check_link;
        mem_rw_s3 = t.mem_rw; rw_s3 = t.rw; load_link_s3 = t.load_link;
        alu_imm_s3 = t.alu_imm; halt_s3 = t.halt;
        waddr_s3 = t.waddr; r1_addr_s3 = t.r1_addr; r2_addr_s3 = t.r2_addr; shamt_s3 = t.shamt;
        r1_data_s3 = t.r1_data; r2_data_s3 = t.r2_data; sign_ext_imm_s3 = t.imm;
        alu_op_s3 = t.op; byte_en_s3 = t.byte_en;
        rw_s4 = t.rw4; sel_mem_s4 = t.sel_mem4; waddr_s4 = t.waddr4; alu_out_s4 = t.alu_out4;
        rw_s5 = t.rw5; waddr_s5 = t.waddr5; wdata_s5 = t.wdata5;
    endtask

    // Issues one op, lets one edge pass, and leaves time just after that edge.
    task automatic step(input txn_t t, output exp_t e);
        drive(t);
        e = model_step(t);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input txn_t t);
        drive(t);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_link_valid = 1'b0;
        m_link_addr  = 32'h0;
        m_halted     = 1'b0;
    endtask

    function automatic txn_t mk_mem(input logic [31:0] base, input logic [31:0] off);
        txn_t t;
        t = nop_txn();
        t.r1_addr = 5'd4; t.r1_data = base; t.imm = off; t.waddr = 5'd2;
        return t;
    endfunction

    task automatic test_reset();
        do_reset(nop_txn());
        n_cmp++;
        if (observe() !== RESET_EXP) begin
            n_err++; $display("FAIL reset_state: got %h want %h", observe(), RESET_EXP);
        end
    endtask

    task automatic test_add();
        txn_t t; exp_t e;
        t = nop_txn();
        t.rw = 0; t.waddr = 5'd3; t.r1_addr = 5'd1; t.r2_addr = 5'd2;
        t.r1_data = 32'd5; t.r2_data = 32'd7; t.op = 4'd0;
        step(t, e);
        n_cmp++;
        if (alu_out_s4_o !== 32'd12) begin n_err++; $display("FAIL add_result: got %0d want 12", alu_out_s4_o); end
        n_cmp++;
        if (rw_s4_o !== 1'b0 || waddr_s4_o !== 5'd3) begin
            n_err++; $display("FAIL add_ctrl: got rw=%b waddr=%0d want rw=0 waddr=3", rw_s4_o, waddr_s4_o);
        end
        n_cmp++;
        if (observe() !== e) begin n_err++; $display("FAIL add_model: got %h want %h", observe(), e); end
    endtask

    task automatic test_forwarding();
        txn_t t; exp_t e;
        t = nop_txn();
        t.rw = 0; t.waddr = 5'd5; t.r1_addr = 5'd1; t.r1_data = 32'hDEAD; t.alu_imm = 1; t.imm = 32'd1;
        t.r2_addr = 5'd1; t.r2_data = 32'hBEEF;
        t.rw4 = 0; t.waddr4 = 5'd1; t.alu_out4 = 32'h10;
        t.rw5 = 0; t.waddr5 = 5'd1; t.wdata5 = 32'h20;
        step(t, e);
        n_cmp++;
        if (alu_out_s4_o !== 32'h11 || wdata_s4_o !== 32'h10) begin
            n_err++; $display("FAIL fwd_mem_priority: got %h/%h want 11/10", alu_out_s4_o, wdata_s4_o);
        end
        t.rw4 = 1;
        step(t, e);
        n_cmp++;
        if (alu_out_s4_o !== 32'h21 || wdata_s4_o !== 32'h20) begin
            n_err++; $display("FAIL fwd_wb: got %h/%h want 21/20", alu_out_s4_o, wdata_s4_o);
        end
        t.rw4 = 0; t.sel_mem4 = 1;
        step(t, e);
        n_cmp++;
        if (alu_out_s4_o !== 32'h21) begin
            n_err++; $display("FAIL fwd_skip_load: got %h want 21", alu_out_s4_o);
        end
        t.sel_mem4 = 0; t.r1_addr = 5'd0; t.r1_data = 32'h7; t.waddr4 = 5'd0; t.waddr5 = 5'd0;
        step(t, e);
        n_cmp++;
        if (alu_out_s4_o !== 32'h8) begin n_err++; $display("FAIL fwd_r0: got %h want 8", alu_out_s4_o); end
        n_cmp++;
        if (observe() !== e) begin n_err++; $display("FAIL fwd_model: got %h want %h", observe(), e); end
    endtask

    task automatic test_ll_sc();
        txn_t t; exp_t e;
        t = mk_mem(32'h100, 32'h0); t.sel_mem = 1; t.load_link = 0; t.rw = 0;
        step(t, e);
        n_cmp++;
        if (link_valid !== 1'b1 || alu_out_s4_o !== 32'h100) begin
            n_err++; $display("FAIL ll_set: got link=%b addr=%h want 1/100", link_valid, alu_out_s4_o);
        end
        t = mk_mem(32'hF0, 32'h10); t.check_link = 1; t.sel_mem = 1; t.mem_rw = 0; t.atomic = 1;
        step(t, e);
        n_cmp++;
        if (mem_rw_s4_o !== 1'b0 || atomic_s4_o !== 1'b1 || link_valid !== 1'b0) begin
            n_err++; $display("FAIL sc_pass: got mem_rw=%b atomic=%b link=%b want 0/1/0",
                              mem_rw_s4_o, atomic_s4_o, link_valid);
        end
        step(t, e);
        n_cmp++;
        if (mem_rw_s4_o !== 1'b1 || atomic_s4_o !== 1'b0) begin
            n_err++; $display("FAIL sc_second: got mem_rw=%b atomic=%b want 1/0", mem_rw_s4_o, atomic_s4_o);
        end
        t = mk_mem(32'h200, 32'h0); t.sel_mem = 1; t.load_link = 0; t.rw = 0;
        step(t, e);
        t = mk_mem(32'h1FC, 32'h4); t.check_link = 1; t.mem_rw = 0; t.rw = 0;
        step(t, e);
        n_cmp++;
        if (alu_out_s4_o !== 32'h1 || mem_rw_s4_o !== 1'b0) begin
            n_err++; $display("FAIL sc_flag: got alu=%h mem_rw=%b want 1/0", alu_out_s4_o, mem_rw_s4_o);
        end
    endtask

    task automatic test_link_clear();
        txn_t t; exp_t e;
        t = mk_mem(32'h100, 32'h0); t.sel_mem = 1; t.load_link = 0; t.rw = 0;
        step(t, e);
        t = mk_mem(32'h100, 32'h2); t.mem_rw = 0;
        step(t, e);
        n_cmp++;
        if (link_valid !== 1'b0) begin n_err++; $display("FAIL store_clears: got link=%b want 0", link_valid); end
        t = mk_mem(32'h100, 32'h0); t.check_link = 1; t.sel_mem = 1; t.mem_rw = 0;
        step(t, e);
        n_cmp++;
        if (mem_rw_s4_o !== 1'b1) begin n_err++; $display("FAIL sc_after_store: got mem_rw=%b want 1", mem_rw_s4_o); end
        t = mk_mem(32'h100, 32'h0); t.sel_mem = 1; t.load_link = 0; t.rw = 0;
        step(t, e);
        t = mk_mem(32'h200, 32'h0); t.mem_rw = 0;
        step(t, e);
        n_cmp++;
        if (link_valid !== 1'b1) begin n_err++; $display("FAIL store_other_word: got link=%b want 1", link_valid); end
        t = mk_mem(32'h100, 32'h4); t.check_link = 1; t.sel_mem = 1; t.mem_rw = 0;
        step(t, e);
        n_cmp++;
        if (mem_rw_s4_o !== 1'b1 || link_valid !== 1'b0) begin
            n_err++; $display("FAIL sc_wrong_addr: got mem_rw=%b link=%b want 1/0", mem_rw_s4_o, link_valid);
        end
    endtask

    task automatic test_alu_edges();
        logic [3:0]  ops[5]  = '{4'd8, 4'd9, 4'd10, 4'd1, 4'd13};
        logic [31:0] av[5]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1234};
        logic [31:0] bv[5]   = '{32'h8000_0000, 32'h1, 32'h1, 32'h1, 32'h5678};
        logic [31:0] want[5] = '{32'hF800_0000, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0};
        txn_t t; exp_t e;
        for (int i = 0; i < 5; i++) begin
            t = nop_txn();
            t.rw = 0; t.waddr = 5'd9; t.r1_addr = 5'd1; t.r2_addr = 5'd2;
            t.r1_data = av[i]; t.r2_data = bv[i]; t.op = ops[i]; t.shamt = 5'd4;
            step(t, e);
            n_cmp++;
            if (alu_out_s4_o !== want[i]) begin
                n_err++; $display("FAIL alu_edge op=%0d: got %h want %h", ops[i], alu_out_s4_o, want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pool[4] = '{32'h100, 32'h104, 32'h200, 32'h0FC};
        logic [31:0] offs[4] = '{32'h0, 32'h2, 32'h4, 32'hFFFF_FFFC};
        txn_t t; exp_t e; exp_t got;
        do_reset(nop_txn());
        for (int i = 0; i < 400; i++) begin
            t = nop_txn();
            t.rw = 1'($urandom_range(0, 1)); t.waddr = 5'($urandom_range(0, 7));
            t.r1_addr = 5'($urandom_range(0, 7)); t.r2_addr = 5'($urandom_range(0, 7));
            t.r1_data = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
            t.r2_data = $urandom; t.shamt = 5'($urandom_range(0, 31)); t.op = 4'($urandom_range(0, 15));
            t.imm = ($urandom_range(0, 1) == 1) ? offs[$urandom_range(0, 3)] : $urandom;
            t.alu_imm = 1'($urandom_range(0, 1)); t.byte_en = 4'($urandom_range(0, 15));
            t.atomic = 1'($urandom_range(0, 1));
            t.rw4 = 1'($urandom_range(0, 1)); t.sel_mem4 = 1'($urandom_range(0, 1));
            t.waddr4 = 5'($urandom_range(0, 7)); t.alu_out4 = pool[$urandom_range(0, 3)];
            t.rw5 = 1'($urandom_range(0, 1)); t.waddr5 = 5'($urandom_range(0, 7)); t.wdata5 = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: begin t.sel_mem = 1; t.load_link = 1'($urandom_range(0, 1)); end
                2: t.mem_rw = 0;
                3: begin t.check_link = 1; t.sel_mem = 1'($urandom_range(0, 1)); t.mem_rw = 0; end
                4: begin t.rw = 1; t.mem_rw = 1; end
                default: begin t.sel_mem = 1; t.load_link = 0; end
            endcase
            drive(t);
            exp_q.push_back(model_step(t));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            got = observe();
            n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL random[%0d]: got %h want %h", i, got, e); end
        end
    endtask

    task automatic test_halt();
        txn_t t; exp_t e;
        t = nop_txn();
        t.rw = 0; t.waddr = 5'd3; t.r1_addr = 5'd1; t.r2_addr = 5'd2;
        t.r1_data = 32'd5; t.r2_data = 32'd7; t.halt = 1;
        step(t, e);
        n_cmp++;
        if (halt_s4_o !== 1'b1 || alu_out_s4_o !== 32'd12) begin
            n_err++; $display("FAIL halt_pass: got halt=%b alu=%0d want 1/12", halt_s4_o, alu_out_s4_o);
        end
        t.halt = 0;
        step(t, e);
        t = mk_mem(32'h300, 32'h0); t.sel_mem = 1; t.load_link = 0; t.rw = 0;
        step(t, e);
        n_cmp++;
        if (halt_s4_o !== 1'b0 || rw_s4_o !== 1'b1 || alu_out_s4_o !== 32'h0 || byte_en_s4_o !== 4'hF) begin
            n_err++; $display("FAIL halted_nop: got halt=%b rw=%b alu=%h be=%h want 0/1/0/f",
                              halt_s4_o, rw_s4_o, alu_out_s4_o, byte_en_s4_o);
        end
        n_cmp++;
        if (observe() !== e) begin n_err++; $display("FAIL halted_model: got %h want %h", observe(), e); end
    endtask

    task automatic test_reset_mid();
        txn_t t; exp_t e;
        t = nop_txn();
        t.rw = 0; t.waddr = 5'd3; t.r1_addr = 5'd1; t.r1_data = 32'd5; t.alu_imm = 1; t.imm = 32'd7;
        do_reset(t);
        n_cmp++;
        if (observe() !== RESET_EXP) begin n_err++; $display("FAIL reset_mid: got %h want %h", observe(), RESET_EXP); end
        step(t, e);
        n_cmp++;
        if (alu_out_s4_o !== 32'd12 || rw_s4_o !== 1'b0) begin
            n_err++; $display("FAIL after_reset: got alu=%0d rw=%b want 12/0", alu_out_s4_o, rw_s4_o);
        end
    endtask

    initial begin
        m_link_valid = 1'b0;
        m_link_addr  = 32'h0;
        m_halted     = 1'b0;
        drive(nop_txn());
        #2;
        test_reset();
        test_add();
        test_forwarding();
        test_ll_sc();
        test_link_clear();
        test_alu_edges();
        test_random();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
